// File: rtl/cbus_initiator_pkg.sv
// Shared encodings and helpers for the c_* configuration bus initiator.
package cbus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    TURN
  } state_t;

  // True when the access cannot be issued: reserved size or natural misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic rej;
    case (size)
      SZ_BYTE: rej = 1'b0;
      SZ_HALF: rej = addr_lo[0];
      SZ_WORD: rej = (addr_lo != 2'b00);
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

  // Mask applied to LSB-aligned read data so narrow reads come back zero-extended.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cbus_initiator_if.sv
// Request/response port plus c_* bus signals seen by the initiator.
interface cbus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        c_valid;
  logic        c_write;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  c_size;
  logic        c_ready;
  logic [31:0] c_rdata;

  // Initiator side: serves local requests and masters the c_* bus.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output c_valid, c_write, c_addr, c_wdata, c_size,
    input  c_ready, c_rdata
  );

  // Environment side: request source and bus responder.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  c_valid, c_write, c_addr, c_wdata, c_size,
    output c_ready, c_rdata
  );
endinterface

// File: rtl/cbus_initiator.sv
// Single-outstanding initiator for the c_* configuration bus with alignment
// check, bounded wait for c_ready and a one-cycle response strobe.
module cbus_initiator
  import cbus_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              c_clk,
  input  logic              c_rst,
  cbus_initiator_if.master  bus,
  output logic              busy
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        reject;
  logic        timeout_hit;

  assign accept      = (state == IDLE) && bus.req_valid;
  assign reject      = misaligned(size_q, addr_q[1:0]);
  assign timeout_hit = (wait_cnt == TIMEOUT_M1);

  // State register.
  always_ff @(posedge c_clk) begin
    if (c_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; c_ready only matters while the bus cycle is live in REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.req_valid) state_nxt = CHECK;
      CHECK: state_nxt = reject ? TURN : REQ;
      REQ:   if (bus.c_ready || timeout_hit) state_nxt = TURN;
      TURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly; TURN is the response cycle.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.c_valid   = (state == REQ);
    bus.rsp_valid = (state == TURN);
    busy          = (state != IDLE);
  end

  // Request capture, wait counter and held response registers.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
      end
      wait_cnt <= (state == REQ) ? wait_cnt + 8'd1 : '0;
      if (state == CHECK && reject) begin
        err_q   <= 1'b1;
        rdata_q <= ERR_DATA;
      end
      if (state == REQ) begin
        if (bus.c_ready) begin
          err_q   <= 1'b0;
          rdata_q <= write_q ? '0 : (bus.c_rdata & size_mask(size_q));
        end else if (timeout_hit) begin
          err_q   <= 1'b1;
          rdata_q <= ERR_DATA;
        end
      end
    end
  end

  assign bus.c_write   = write_q;
  assign bus.c_addr    = addr_q;
  assign bus.c_wdata   = wdata_q;
  assign bus.c_size    = size_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_cbus_initiator.sv
// Self-checking bench for cbus_initiator with a registered-ready responder model.
module tb_cbus_initiator;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic c_clk = 1'b0;
  logic c_rst = 1'b1;
  logic busy;

  int checks = 0;
  int fails  = 0;

  logic        resp_en   = 1'b1;
  logic        pulse_rdy = 1'b0;
  logic        ready_q   = 1'b0;
  logic [31:0] rdata_drv = '0;

  cbus_initiator_if bus ();

  cbus_initiator #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .c_clk (c_clk),
    .c_rst (c_rst),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 c_clk = ~c_clk;

  // Responder: c_ready is a registered copy of c_valid, plus optional spurious pulses.
  always @(posedge c_clk) ready_q <= bus.c_valid & resp_en;
  assign bus.c_ready = ready_q | pulse_rdy;
  assign bus.c_rdata = ready_q ? rdata_drv : 32'hA5A5_5A5A;

  function automatic bit model_reject(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] model_rdata(input logic w, input logic [1:0] s, input logic [31:0] rd);
    if (w) return 32'd0;
    if (s == 2'd0) return rd % 256;
    if (s == 2'd1) return rd % 65536;
    return rd;
  endfunction

  // Issues one request and records what the bus and response port did, cycle by cycle
  // counted from the accepting edge.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s,
                         output int rsp_n, output int ready_n, output int vcyc,
                         output int strobes, output logic err, output logic [31:0] rd,
                         output logic [31:0] held, output logic bus_ok);
    rsp_n = -1; ready_n = -1; vcyc = 0; strobes = 0;
    err = 1'b0; rd = '0; held = '0; bus_ok = 1'b1;
    @(negedge c_clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_size  = s;
    @(posedge c_clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_size  = 2'($urandom);
    for (int n = 1; n <= 300; n++) begin
      @(negedge c_clk);
      if (bus.c_valid) begin
        vcyc++;
        if (bus.c_addr !== a || bus.c_wdata !== d || bus.c_size !== s || bus.c_write !== w)
          bus_ok = 1'b0;
      end
      if (bus.rsp_valid) begin
        strobes++;
        if (rsp_n < 0) begin
          rsp_n = n;
          err   = bus.rsp_err;
          rd    = bus.rsp_rdata;
        end
      end
      if (bus.req_ready && ready_n < 0) begin
        ready_n = n;
        held    = bus.rsp_rdata;
      end
      if (ready_n >= 0 && n >= ready_n + 2) break;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_size = '0;
    c_rst = 1'b1;
    repeat (2) @(posedge c_clk);
    #1 c_rst = 1'b0;
    @(negedge c_clk);
    checks++; if (bus.c_valid !== 1'b0) begin fails++; $display("FAIL reset_c_valid got %b want 0", bus.c_valid); end
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== 32'd0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    checks++; if ({bus.c_addr, bus.c_wdata, bus.c_size, bus.c_write} !== 67'd0) begin fails++; $display("FAIL reset_c_fields got %h/%h/%0d/%b want all 0", bus.c_addr, bus.c_wdata, bus.c_size, bus.c_write); end
    checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_write_word();
    int rn, yn, vc, st; logic e, ok; logic [31:0] r, h;
    run_txn(1'b1, 32'h4, 32'h0000_03E8, 2'd2, rn, yn, vc, st, e, r, h, ok);
    checks++; if (vc != 2) begin fails++; $display("FAIL wr_cvalid_cycles got %0d want 2", vc); end
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL wr_bus_fields got %b want 1", ok); end
    checks++; if (rn != 4) begin fails++; $display("FAIL wr_rsp_latency got %0d want 4", rn); end
    checks++; if (e !== 1'b0 || r !== 32'd0) begin fails++; $display("FAIL wr_rsp got err=%b data=%h want err=0 data=0", e, r); end
    checks++; if (yn != 5) begin fails++; $display("FAIL wr_ready_latency got %0d want 5", yn); end
    checks++; if (st != 1) begin fails++; $display("FAIL wr_strobes got %0d want 1", st); end
  endtask

  task automatic test_read_sizes();
    int rn, yn, vc, st; logic e, ok; logic [31:0] r, h;
    rdata_drv = 32'h1234_5678;
    run_txn(1'b0, 32'h8, 32'h0, 2'd2, rn, yn, vc, st, e, r, h, ok);
    checks++; if (e !== 1'b0 || r !== 32'h1234_5678) begin fails++; $display("FAIL rd_word got err=%b data=%h want err=0 data=12345678", e, r); end
    checks++; if (rn != 4) begin fails++; $display("FAIL rd_word_latency got %0d want 4", rn); end
    rdata_drv = 32'hFFFF_FFAB;
    run_txn(1'b0, 32'h9, 32'h0, 2'd0, rn, yn, vc, st, e, r, h, ok);
    checks++; if (e !== 1'b0 || r !== 32'h0000_00AB) begin fails++; $display("FAIL rd_byte got err=%b data=%h want err=0 data=000000ab", e, r); end
    checks++; if (h !== 32'h0000_00AB) begin fails++; $display("FAIL rd_byte_held got %h want 000000ab", h); end
  endtask

  task automatic test_reject();
    int rn, yn, vc, st; logic e, ok; logic [31:0] r, h;
    run_txn(1'b0, 32'h2, 32'h0, 2'd2, rn, yn, vc, st, e, r, h, ok);
    checks++; if (vc != 0) begin fails++; $display("FAIL rej_word_cvalid got %0d want 0", vc); end
    checks++; if (rn != 2) begin fails++; $display("FAIL rej_word_latency got %0d want 2", rn); end
    checks++; if (e !== 1'b1 || r !== ERR_DATA) begin fails++; $display("FAIL rej_word_rsp got err=%b data=%h want err=1 data=deadbeef", e, r); end
    checks++; if (yn != 3) begin fails++; $display("FAIL rej_word_ready got %0d want 3", yn); end
    run_txn(1'b1, 32'h0, 32'h55, 2'd3, rn, yn, vc, st, e, r, h, ok);
    checks++; if (vc != 0 || rn != 2) begin fails++; $display("FAIL rej_size3 got cvalid=%0d lat=%0d want 0/2", vc, rn); end
    checks++; if (e !== 1'b1 || r !== ERR_DATA) begin fails++; $display("FAIL rej_size3_rsp got err=%b data=%h want err=1 data=deadbeef", e, r); end
  endtask

  task automatic test_timeout();
    int rn, yn, vc, st; logic e, ok; logic [31:0] r, h;
    resp_en = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, 2'd2, rn, yn, vc, st, e, r, h, ok);
    checks++; if (vc != TIMEOUT) begin fails++; $display("FAIL to_cvalid_cycles got %0d want %0d", vc, TIMEOUT); end
    checks++; if (rn != TIMEOUT + 2) begin fails++; $display("FAIL to_latency got %0d want %0d", rn, TIMEOUT + 2); end
    checks++; if (e !== 1'b1 || r !== ERR_DATA) begin fails++; $display("FAIL to_rsp got err=%b data=%h want err=1 data=deadbeef", e, r); end
    checks++; if (st != 1) begin fails++; $display("FAIL to_strobes got %0d want 1", st); end
    resp_en = 1'b1;
    rdata_drv = 32'hCAFE_F00D;
    run_txn(1'b0, 32'h12, 32'h0, 2'd1, rn, yn, vc, st, e, r, h, ok);
    checks++; if (e !== 1'b0 || r !== 32'h0000_F00D || rn != 4) begin fails++; $display("FAIL to_recover got err=%b data=%h lat=%0d want 0/0000f00d/4", e, r, rn); end
  endtask

  task automatic test_stale_ready();
    int rn, yn, vc, st, extra; logic e, ok; logic [31:0] r, h;
    extra = 0;
    @(negedge c_clk) pulse_rdy = 1'b1;
    @(negedge c_clk) pulse_rdy = 1'b0;
    if (bus.rsp_valid) extra++;
    repeat (3) begin
      @(negedge c_clk);
      if (bus.rsp_valid || busy) extra++;
    end
    checks++; if (extra != 0) begin fails++; $display("FAIL idle_pulse_effect got %0d want 0", extra); end
    rdata_drv = 32'h8765_4321;
    run_txn(1'b0, 32'h40, 32'h0, 2'd2, rn, yn, vc, st, e, r, h, ok);
    checks++; if (st != 1) begin fails++; $display("FAIL stale_turn_strobes got %0d want 1", st); end
    checks++; if (e !== 1'b0 || r !== 32'h8765_4321) begin fails++; $display("FAIL stale_data got err=%b data=%h want 0/87654321", e, r); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    rdata_drv = 32'h1111_2222;
    @(negedge c_clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h20; bus.req_size = 2'd2;
    @(posedge c_clk);
    #1 bus.req_valid = 1'b0;
    @(negedge c_clk);
    @(negedge c_clk);
    checks++; if (bus.c_valid !== 1'b1) begin fails++; $display("FAIL rstmid_cvalid_before got %b want 1", bus.c_valid); end
    @(negedge c_clk);
    c_rst = 1'b1;
    @(negedge c_clk);
    checks++; if (bus.c_valid !== 1'b0) begin fails++; $display("FAIL rstmid_cvalid_after got %b want 0", bus.c_valid); end
    if (bus.rsp_valid) seen++;
    c_rst = 1'b0;
    repeat (4) begin
      @(negedge c_clk);
      if (bus.rsp_valid) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL rstmid_rsp got %0d strobes want 0", seen); end
    checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_idle got busy=%b ready=%b want 0/1", busy, bus.req_ready); end
  endtask

  task automatic test_random();
    int rn, yn, vc, st; logic e, ok; logic [31:0] r, h, a, d, exp_d;
    logic w; logic [1:0] s; bit rej;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom);
      s = 2'($urandom);
      a = $urandom;
      d = $urandom;
      rdata_drv = $urandom;
      rej = model_reject(s, a);
      exp_d = rej ? ERR_DATA : model_rdata(w, s, rdata_drv);
      run_txn(w, a, d, s, rn, yn, vc, st, e, r, h, ok);
      checks++;
      if (rn != (rej ? 2 : 4) || yn != (rej ? 3 : 5) || vc != (rej ? 0 : 2) || st != 1 || ok !== 1'b1) begin
        fails++;
        $display("FAIL rand_timing[%0d] got lat=%0d rdy=%0d cv=%0d st=%0d ok=%b want %0d/%0d/%0d/1/1",
                 i, rn, yn, vc, st, ok, rej ? 2 : 4, rej ? 3 : 5, rej ? 0 : 2);
      end
      checks++;
      if (e !== 1'(rej) || r !== exp_d || h !== exp_d) begin
        fails++;
        $display("FAIL rand_rsp[%0d] got err=%b data=%h held=%h want err=%b data=%h", i, e, r, h, rej, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_word();
    test_read_sizes();
    test_reject();
    test_timeout();
    test_stale_ready();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cbus_initiator.md
Name: cbus_initiator

Overview:
- Initiator (master) end of the c_* configuration bus that the bus-side peripherals (timer, interrupt and similar blocks) respond on.
- Accepts one request at a time from a local valid/ready request port.
- Drives c_valid/c_write/c_addr/c_wdata/c_size to a responder and waits for c_ready, with a timeout.
- Returns read data and an error flag on a one-cycle response strobe.
- Sits between a CPU load/store unit or debug port and the peripheral configuration bus.

Parameters:
- TIMEOUT, 16, number of cycles c_valid may stay high without c_ready before the access is aborted (range 1..255).
- ERR_DATA, 32'hDEADBEEF, value returned on rsp_rdata for an aborted or rejected access.

Ports:
- c_clk  in  1  bus clock; the only clock
- c_rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  32  write data, LSB-aligned
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  timeout/reject; valid with rsp_valid
- rsp_rdata  out  32  read data, LSB-aligned, zero-extended to size
- c_valid  out  1  bus request
- c_write  out  1
- c_addr  out  32
- c_wdata  out  32  LSB-aligned; responder shifts by addr[1:0]
- c_size  out  2
- c_ready  in  1  responder completion; registered copy of c_valid at responder
- c_rdata  in  32  valid in the cycle c_ready is high
- busy  out  1  state != IDLE

Behaviour:
- Reset (c_rst=1 at posedge): state=IDLE.
  - c_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - c_addr/c_wdata/c_size/c_write=0, wait counter=0.
  - req_ready=1 from the first cycle after reset.
  - Reset mid-access drops c_valid at that edge and produces no response.
- States: IDLE, CHECK, REQ, TURN.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture the request into the c_* output registers and go to CHECK.
- CHECK (1 cycle, c_valid=0): alignment check.
  - Reject if size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
  - Reject -> TURN with rsp_valid=1, rsp_err=1, rsp_rdata=ERR_DATA; no bus cycle is issued.
  - Accept -> REQ.
- REQ:
  - c_valid=1; the wait counter increments each cycle.
  - If c_ready is sampled high: go to TURN next edge.
    - Registered outputs: c_valid=0, rsp_valid=1, rsp_err=0.
    - rsp_rdata = 0 on writes; on reads, c_rdata masked to size (byte [7:0], half [15:0], word [31:0]).
  - Else if counter == TIMEOUT-1: go to TURN with c_valid=0, rsp_valid=1, rsp_err=1, rsp_rdata=ERR_DATA.
- TURN (exactly 1 cycle):
  - c_valid=0 and c_ready is ignored. The responder registers c_valid, so c_ready is still high here from the last REQ cycle.
  - rsp_valid falls, then IDLE.
- Latency for request handshake at edge A with a 1-cycle responder:
  - CHECK in A+1, c_valid high A+2.
  - c_ready high A+3, rsp_valid high A+4.
  - req_ready high A+5. Minimum issue interval is 5 cycles.
- c_ready high in IDLE or CHECK is ignored (stale or spurious).
- Request signals are sampled only at acceptance; later changes have no effect.
- rsp_valid is never asserted twice for one request. There is no backpressure on rsp.
- rsp_rdata and rsp_err hold their values until the next response.

Decomposition:
- Package cbus_pkg:
  - Size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - State enum: IDLE, CHECK, REQ, TURN.
  - Misalignment function (size, addr[1:0]) -> reject.
  - Size mask function (size) -> 32-bit mask.
- Single module; no sub-module. The timeout counter is an 8-bit register local to REQ.

Test Plan:
- Write, size=2, addr 0x4, data 0x000003E8, 1-cycle responder -> c_valid high for exactly 2 cycles carrying those values; rsp_valid at A+4 with rsp_err=0, rsp_rdata=0; req_ready back at A+5.
- Read, size=2, addr 0x8, responder c_rdata=0x12345678 -> rsp_rdata=0x12345678, rsp_err=0; then a read of size=0 at addr 0x9 with c_rdata=0xFFFFFFAB -> rsp_rdata=0x000000AB.
- Misaligned word read at addr 0x2 and a size=3 request -> c_valid never rises; rsp_valid at A+2 with rsp_err=1, rsp_rdata=0xDEADBEEF.
- Silent responder (c_ready held 0), TIMEOUT=16 -> c_valid high exactly 16 cycles; rsp_err=1, rsp_rdata=0xDEADBEEF; next request proceeds normally.
- Stale c_ready held high during TURN, and c_ready=1 pulsed in IDLE -> no extra rsp_valid; the following access completes with correct data.
- c_rst asserted during REQ (cycle A+3 of a read) -> c_valid=0 next cycle; no rsp_valid; busy=0, req_ready=1 after reset release.
